serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub.sv | 126 ++++++++++++
 tb/tb_serial_add_sub.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, registered carry
// between digits, start/done handshake with registered result and flags.
module serial_add_sub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] opa, opa_nx, opb, opb_nx, acc, acc_nx;
    logic             carry, carry_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             busy_nx, done_nx, cout_nx, ovf_nx, zero_nx;
    logic [WIDTH-1:0] result_nx;
    logic [DIGIT-1:0] da, db;
    logic [DIGIT:0]   dsum;
    int unsigned      idx;

    // State, operand, accumulator and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            state     <= state_nx;
            opa       <= opa_nx;
            opb       <= opb_nx;
            acc       <= acc_nx;
            carry     <= carry_nx;
            cnt       <= cnt_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            result    <= result_nx;
            carry_out <= cout_nx;
            overflow  <= ovf_nx;
            zero      <= zero_nx;
        end
    end

    // Next-state, digit datapath and output-register loads
    always_comb begin
        state_nx  = state;
        opa_nx    = opa;
        opb_nx    = opb;
        acc_nx    = acc;
        carry_nx  = carry;
        cnt_nx    = cnt;
        busy_nx   = 1'b0;
        done_nx   = 1'b0;
        result_nx = result;
        cout_nx   = carry_out;
        ovf_nx    = overflow;
        zero_nx   = zero;
        idx       = 32'(cnt) * DIGIT;
        da        = '0;
        db        = '0;
        dsum      = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    opa_nx   = a;
                    opb_nx   = sub ? ~b : b;
                    carry_nx = sub;
                    cnt_nx   = '0;
                    busy_nx  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                da   = opa[idx +: DIGIT];
                db   = opb[idx +: DIGIT];
                dsum = {1'b0, da} + {1'b0, db} + (DIGIT+1)'(carry);
                acc_nx[idx +: DIGIT] = dsum[DIGIT-1:0];
                carry_nx = dsum[DIGIT];
                if (cnt == CW'(N - 1)) begin
                    // acc_nx already holds the final digit here
                    result_nx = acc_nx;
                    cout_nx   = dsum[DIGIT];
                    ovf_nx    = opa[WIDTH-1] ^ opb[WIDTH-1] ^ acc_nx[WIDTH-1] ^ dsum[DIGIT];
                    zero_nx   = (acc_nx == '0);
                    done_nx   = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = DONE;
                end else begin
                    cnt_nx  = cnt + CW'(1);
                    busy_nx = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: a 32/4 instance (N=8) and an 8/8 instance (N=1).
module tb_serial_add_sub;

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sub;
    logic [31:0] a, b;
    logic        busy, done, carry_out, overflow, zero;
    logic [31:0] result;

    logic        start8, sub8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, carry_out8, overflow8, zero8;
    logic [7:0]  result8;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(32), .DIGIT(4)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .zero(zero)
    );

    serial_add_sub #(.WIDTH(8), .DIGIT(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .carry_out(carry_out8),
        .overflow(overflow8), .zero(zero8)
    );

    function automatic exp_t model32(input logic s, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [31:0] yb;
        logic [32:0] t;
        yb   = s ? ~y : y;
        t    = {1'b0, x} + {1'b0, yb} + 33'(s);
        e.res = t[31:0];
        e.co  = t[32];
        e.ov  = (x[31] == yb[31]) && (t[31] != x[31]);
        e.z   = (t[31:0] == 32'h0);
        return e;
    endfunction

    // Caller is at a negedge; drives one op on the 32-bit instance and checks it.
    task automatic run32(input string name, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input exp_t ex);
        int          cyc;
        int          bc;
        logic        held;
        logic        both;
        logic [31:0] prev;
        exp_t        e;
        prev = result;
        held = 1'b1;
        both = 1'b0;
        sub = s; a = x; b = y; start = 1'b1;
        sb.push_back(ex);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        bc  = 0;
        while (!done && cyc < 40) begin
            if (busy) bc++;
            if (result !== prev) held = 1'b0;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done not seen in %0d cycles", name, cyc);
            void'(sb.pop_front());
        end else begin
            if (busy) both = 1'b1;
            checks++;
            if (bc != 8 || cyc != 8) begin
                errors++;
                $display("FAIL %s latency: busy %0d cycles, done after %0d, required 8/8", name, bc, cyc);
            end
            checks++;
            if (!held || both) begin
                errors++;
                $display("FAIL %s hold: result changed early=%0b busy&done=%0b, required 0/0", name, !held, both);
            end
            e = sb.pop_front();
            checks++;
            if (result !== e.res || carry_out !== e.co || overflow !== e.ov || zero !== e.z) begin
                errors++;
                $display("FAIL %s result: got %h co=%b ov=%b z=%b, required %h co=%b ov=%b z=%b",
                         name, result, carry_out, overflow, zero, e.res, e.co, e.ov, e.z);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: done=%b busy=%b one cycle later, required 0/0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        int bhigh;
        rst_n = 1'b0;
        start = 1'b0; sub = 1'b0; a = '0; b = '0;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy, done, result, carry_out, overflow, zero} !== 37'h0 ||
            {busy8, done8, result8, carry_out8, overflow8, zero8} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got r32=%h b=%b d=%b co=%b ov=%b z=%b r8=%h, required all 0",
                     result, busy, done, carry_out, overflow, zero, result8);
        end
        bhigh = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || busy8) bhigh++;
        end
        checks++;
        if (bhigh != 0) begin
            errors++;
            $display("FAIL reset_idle: busy high %0d cycles, required 0", bhigh);
        end
    endtask

    task automatic test_directed();
        exp_t e;
        e = '{res: 32'h0000_0000, co: 1'b1, ov: 1'b0, z: 1'b1};
        run32("unsigned_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, e);
        e = '{res: 32'h7FFF_FFFF, co: 1'b1, ov: 1'b1, z: 1'b0};
        run32("sub_overflow", 1'b1, 32'h8000_0000, 32'h0000_0001, e);
        e = '{res: 32'h8000_0000, co: 1'b0, ov: 1'b1, z: 1'b0};
        run32("add_overflow", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, e);
        e = '{res: 32'h0000_0000, co: 1'b1, ov: 1'b0, z: 1'b1};
        run32("sub_equal", 1'b1, 32'h1234_5678, 32'h1234_5678, e);
        e = '{res: 32'hFFFF_FFFF, co: 1'b0, ov: 1'b0, z: 1'b0};
        run32("borrow", 1'b1, 32'h0000_0000, 32'h0000_0001, e);
    endtask

    task automatic test_back_to_back();
        logic        s;
        logic [31:0] x, y;
        for (int i = 0; i < 6; i++) begin
            s = 1'($urandom_range(0, 1));
            x = $urandom();
            y = $urandom();
            run32("random", s, x, y, model32(s, x, y));
        end
    endtask

    task automatic test_handshake();
        int          dcount;
        logic        held;
        logic [31:0] prev;
        exp_t        e;
        prev = result;
        held = 1'b1;
        dcount = 0;
        sub = 1'b0; a = 32'h3; b = 32'h4; start = 1'b1;
        sb.push_back('{res: 32'h0000_0007, co: 1'b0, ov: 1'b0, z: 1'b0});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1; sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (done) begin
                dcount++;
                if (dcount == 1) begin
                    e = sb.pop_front();
                    checks++;
                    if (result !== e.res || carry_out !== e.co || overflow !== e.ov || zero !== e.z) begin
                        errors++;
                        $display("FAIL handshake_result: got %h co=%b ov=%b z=%b, required %h co=%b ov=%b z=%b",
                                 result, carry_out, overflow, zero, e.res, e.co, e.ov, e.z);
                    end
                end
            end else if (dcount == 0 && result !== prev) begin
                held = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (dcount != 1) begin
            errors++;
            $display("FAIL handshake_done_count: got %0d done pulses, required 1", dcount);
            if (dcount == 0) void'(sb.pop_front());
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL handshake_hold: result changed before done, required held %h", prev);
        end
    endtask

    task automatic test_reset_mid();
        int dseen;
        sub = 1'b0; a = 32'h1111_1111; b = 32'h2222_2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, result, carry_out, overflow, zero} !== 37'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got r=%h b=%b d=%b co=%b ov=%b z=%b, required all 0",
                     result, busy, done, carry_out, overflow, zero);
        end
        rst_n = 1'b1;
        dseen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dseen++;
        end
        checks++;
        if (dseen != 0) begin
            errors++;
            $display("FAIL reset_mid_abort: busy/done seen %0d cycles after reset, required 0", dseen);
        end
    endtask

    task automatic test_n1();
        int   cyc;
        int   bc;
        exp_t e;
        sub8 = 1'b1; a8 = 8'h05; b8 = 8'h07; start8 = 1'b1;
        sb.push_back('{res: 32'h0000_00FE, co: 1'b0, ov: 1'b0, z: 1'b0});
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        bc  = 0;
        while (!done8 && cyc < 20) begin
            if (busy8) bc++;
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        checks++;
        if (!done8 || bc != 1 || cyc != 1 || busy8) begin
            errors++;
            $display("FAIL n1_latency: done=%b busy %0d cycles, done after %0d, required 1/1", done8, bc, cyc);
        end
        checks++;
        if ({24'h0, result8} !== e.res || carry_out8 !== e.co || overflow8 !== e.ov || zero8 !== e.z) begin
            errors++;
            $display("FAIL n1_result: got %h co=%b ov=%b z=%b, required %h co=%b ov=%b z=%b",
                     result8, carry_out8, overflow8, zero8, e.res[7:0], e.co, e.ov, e.z);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL n1_pulse: done=%b one cycle later, required 0", done8);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_handshake();
        test_reset_mid();
        test_n1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
